// File: rtl/spi_omega_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// spi_omega_rx
// SPI mode-0 slave receiver for the omega tuning word. The async SPI pins are
// oversampled on CLK67MHZ. A new word is published only when a frame closes
// with exactly WORD_W bits. Any other length produces a frame_err pulse.
//
// Ports
//   CLK67MHZ    in   1       system clock (only clock domain)
//   resetPort   in   1       synchronous active-high reset
//   sckPort     in   1       SPI clock, async, idle low, sampled on rise
//   mosiPort    in   1       SPI data, async, MSB first
//   sselPort    in   1       SPI select, async, active low
//   omega_out   out  WORD_W  last correctly sized word received
//   omega_valid out  1       one-cycle pulse when omega_out updates
//   frame_err   out  1       one-cycle pulse when a frame has the wrong length
// ---------------------------------------------------------------------------
module spi_omega_rx #(
  parameter int WORD_W      = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK67MHZ,
  input  logic              resetPort,
  input  logic              sckPort,
  input  logic              mosiPort,
  input  logic              sselPort,
  output logic [WORD_W-1:0] omega_out,
  output logic              omega_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ssel_sync;
  logic                   r_sck_d;
  logic                   r_ssel_d;
  logic                   r_mosi_d;
  logic                   r_sck_rise;
  logic                   r_ssel_rise;
  logic                   r_ssel_fall;

  logic                   w_sck_s;
  logic                   w_mosi_s;
  logic                   w_ssel_s;

  state_t                 r_state;
  logic [WORD_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic [WORD_W-1:0]      r_omega;
  logic                   r_valid;
  logic                   r_err;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_ssel_s = r_ssel_sync[SYNC_STAGES-1];

  // Synchronisers, edge-detect delay flops and registered edge pulses.
  // The pulses are registered so the FSM decodes from flops only; r_mosi_d
  // is the synchronised mosi value captured alongside the sck edge, so data
  // and clock stay at the same sampling depth.
  always_ff @(posedge CLK67MHZ) begin
    if (resetPort) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_ssel_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ssel_d    <= 1'b0;
      r_mosi_d    <= 1'b0;
      r_sck_rise  <= 1'b0;
      r_ssel_rise <= 1'b0;
      r_ssel_fall <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  sckPort};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosiPort};
      r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], sselPort};
      r_sck_d     <= w_sck_s;
      r_ssel_d    <= w_ssel_s;
      r_mosi_d    <= w_mosi_s;
      r_sck_rise  <= w_sck_s & ~r_sck_d;
      r_ssel_rise <= w_ssel_s & ~r_ssel_d;
      r_ssel_fall <= ~w_ssel_s & r_ssel_d;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge CLK67MHZ) begin
    if (resetPort) begin
      r_state <= WAIT_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_omega <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        // Wait for a deselected bus so a frame cut by reset is never accepted.
        WAIT_IDLE: begin
          if (w_ssel_s) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (r_ssel_fall) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // Frame close wins over a coincident sck edge.
          if (r_ssel_rise) begin
            r_state <= COMMIT;
          end else if (r_sck_rise) begin
            r_shift <= {r_shift[WORD_W-2:0], r_mosi_d};
            // Saturate so very long frames cannot wrap back to WORD_W.
            if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          if (r_cnt == CNT_FULL) begin
            r_omega <= r_shift;
            r_valid <= 1'b1;
          end else begin
            r_err   <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign omega_out   = r_omega;
  assign omega_valid = r_valid;
  assign frame_err   = r_err;

endmodule

// File: tb/tb_spi_omega_rx.sv
`timescale 1ns/1ps
module tb_spi_omega_rx;

  localparam int W    = 40;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          resetPort = 1'b1;
  logic          sckPort = 1'b0;
  logic          mosiPort = 1'b0;
  logic          sselPort = 1'b1;
  logic [W-1:0]  omega_out;
  logic          omega_valid;
  logic          frame_err;

  spi_omega_rx #(.WORD_W(W), .SYNC_STAGES(SYNC)) dut (
    .CLK67MHZ   (clk),
    .resetPort  (resetPort),
    .sckPort    (sckPort),
    .mosiPort   (mosiPort),
    .sselPort   (sselPort),
    .omega_out  (omega_out),
    .omega_valid(omega_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: every cycle with omega_valid high is logged, so a pulse
  // wider than one cycle shows up as an extra entry.
  logic [W-1:0] v_words[$];
  int           v_cyc[$];
  int           e_cnt    = 0;
  int           both_cnt = 0;

  always @(negedge clk) begin
    if (!resetPort) begin
      if (omega_valid) begin
        v_words.push_back(omega_out);
        v_cyc.push_back(cyc);
      end
      if (frame_err) e_cnt = e_cnt + 1;
      if (omega_valid && frame_err) both_cnt = both_cnt + 1;
    end
  end

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] model_omega = '0;   // last word the receiver should hold

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    v_words.delete();
    v_cyc.delete();
    e_cnt = 0;
  endtask

  task automatic send_bits(input logic [63:0] data, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      mosiPort = data[i];
      tick(4);
      sckPort = 1'b1;
      tick(4);
      sckPort = 1'b0;
    end
  endtask

  // Full frame at SCK = clk/8; t_rise is the cycle on which SSEL goes high.
  task automatic send_frame(input logic [63:0] data, input int len, output int t_rise);
    sselPort = 1'b0;
    tick(4);
    send_bits(data, len);
    tick(4);
    sselPort = 1'b1;
    t_rise = cyc;
  endtask

  task automatic test_reset();
    resetPort = 1'b1;
    tick(5);
    n_checks++;
    if (omega_out !== '0) begin n_fail++; $display("FAIL reset_omega got=%h exp=%h", omega_out, 40'h0); end
    n_checks++;
    if (omega_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", omega_valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    resetPort = 1'b0;
    tick(8);
    $display("reset: omega=%h valid=%b err=%b", omega_out, omega_valid, frame_err);
  endtask

  task automatic test_basic();
    int t_rise;
    logic [W-1:0] got;
    int lat;
    clear_mon();
    send_frame(64'h123456789A, W, t_rise);
    tick(12);
    model_omega = 40'h123456789A;
    got = (v_words.size() > 0) ? v_words[0] : 'x;
    lat = (v_cyc.size() > 0) ? v_cyc[0] - t_rise : -1;
    $display("frame len=40 data=123456789a valids=%0d errs=%0d omega=%h latency=%0d", v_words.size(), e_cnt, omega_out, lat);
    n_checks++;
    if (v_words.size() != 1) begin n_fail++; $display("FAIL basic_valid_cycles got=%0d exp=1", v_words.size()); end
    n_checks++;
    if (got !== model_omega) begin n_fail++; $display("FAIL basic_word got=%h exp=%h", got, model_omega); end
    n_checks++;
    if (lat != SYNC + 3) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, SYNC + 3); end
    n_checks++;
    if (e_cnt != 0) begin n_fail++; $display("FAIL basic_err got=%0d exp=0", e_cnt); end
    n_checks++;
    if (omega_out !== model_omega) begin n_fail++; $display("FAIL basic_omega got=%h exp=%h", omega_out, model_omega); end
  endtask

  task automatic test_bad_length(input int len);
    int t_rise;
    logic [63:0] data;
    data = {$urandom, $urandom};
    clear_mon();
    send_frame(data, len, t_rise);
    tick(12);
    $display("frame len=%0d data=%h valids=%0d errs=%0d omega=%h", len, data, v_words.size(), e_cnt, omega_out);
    n_checks++;
    if (e_cnt != 1) begin n_fail++; $display("FAIL badlen%0d_err got=%0d exp=1", len, e_cnt); end
    n_checks++;
    if (v_words.size() != 0) begin n_fail++; $display("FAIL badlen%0d_valid got=%0d exp=0", len, v_words.size()); end
    n_checks++;
    if (omega_out !== model_omega) begin n_fail++; $display("FAIL badlen%0d_omega got=%h exp=%h", len, omega_out, model_omega); end
  endtask

  task automatic test_sck_while_idle();
    int t_rise;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      sckPort = 1'b1; tick(4);
      sckPort = 1'b0; tick(4);
    end
    tick(6);
    send_frame(64'hFF_FFFF_FFFF, W, t_rise);
    tick(12);
    model_omega = 40'hFF_FFFF_FFFF;
    $display("idle sck x10 then frame len=40 data=ffffffffff valids=%0d errs=%0d omega=%h", v_words.size(), e_cnt, omega_out);
    n_checks++;
    if (v_words.size() != 1) begin n_fail++; $display("FAIL idlesck_valid got=%0d exp=1", v_words.size()); end
    n_checks++;
    if (e_cnt != 0) begin n_fail++; $display("FAIL idlesck_err got=%0d exp=0", e_cnt); end
    n_checks++;
    if (omega_out !== model_omega) begin n_fail++; $display("FAIL idlesck_omega got=%h exp=%h", omega_out, model_omega); end
  endtask

  task automatic test_reset_midframe();
    int t_rise;
    logic [W-1:0] got;
    sselPort = 1'b0;
    tick(4);
    send_bits(64'hABCDE, 20);
    resetPort = 1'b1;
    tick(3);
    n_checks++;
    if (omega_out !== '0) begin n_fail++; $display("FAIL midreset_omega got=%h exp=%h", omega_out, 40'h0); end
    resetPort = 1'b0;
    model_omega = '0;
    clear_mon();
    // Remaining 20 bits with SSEL still low: 40 bits on the wire in total.
    send_bits(64'h12345, 20);
    tick(4);
    sselPort = 1'b1;
    tick(12);
    $display("reset mid-frame: valids=%0d errs=%0d omega=%h", v_words.size(), e_cnt, omega_out);
    n_checks++;
    if (v_words.size() != 0 || e_cnt != 0) begin n_fail++; $display("FAIL midreset_pulses got=%0d/%0d exp=0/0", v_words.size(), e_cnt); end
    n_checks++;
    if (omega_out !== model_omega) begin n_fail++; $display("FAIL midreset_hold got=%h exp=%h", omega_out, model_omega); end
    clear_mon();
    send_frame(64'h1, W, t_rise);
    tick(12);
    model_omega = 40'h1;
    got = (v_words.size() > 0) ? v_words[0] : 'x;
    $display("frame len=40 data=0000000001 valids=%0d errs=%0d omega=%h", v_words.size(), e_cnt, omega_out);
    n_checks++;
    if (v_words.size() != 1) begin n_fail++; $display("FAIL postreset_valid got=%0d exp=1", v_words.size()); end
    n_checks++;
    if (got !== model_omega) begin n_fail++; $display("FAIL postreset_word got=%h exp=%h", got, model_omega); end
  endtask

  task automatic test_back_to_back();
    int t_rise;
    logic [W-1:0] w0, w1;
    clear_mon();
    send_frame(64'hAA_AAAA_AAAA, W, t_rise);
    tick(SYNC + 2);
    send_frame(64'h55_5555_5555, W, t_rise);
    tick(12);
    model_omega = 40'h55_5555_5555;
    w0 = (v_words.size() > 0) ? v_words[0] : 'x;
    w1 = (v_words.size() > 1) ? v_words[1] : 'x;
    $display("back-to-back: valids=%0d errs=%0d words=%h,%h", v_words.size(), e_cnt, w0, w1);
    n_checks++;
    if (v_words.size() != 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", v_words.size()); end
    n_checks++;
    if (w0 !== 40'hAA_AAAA_AAAA) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", w0, 40'hAA_AAAA_AAAA); end
    n_checks++;
    if (w1 !== 40'h55_5555_5555) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", w1, 40'h55_5555_5555); end
    n_checks++;
    if (e_cnt != 0) begin n_fail++; $display("FAIL b2b_err got=%0d exp=0", e_cnt); end
  endtask

  // Random lengths and data against the model: only an exact-length frame
  // updates the word, anything else raises one error and holds the word.
  task automatic test_random(input int n);
    int t_rise;
    int len;
    int sel;
    logic [63:0] data;
    int exp_v;
    int exp_e;
    logic [W-1:0] got;
    for (int k = 0; k < n; k++) begin
      sel  = $urandom_range(0, 3);
      len  = (sel == 0) ? $urandom_range(1, W - 1) : (sel == 1) ? $urandom_range(W + 1, 64) : W;
      data = {$urandom, $urandom};
      if (len == W) begin
        model_omega = data[W-1:0];
        exp_v = 1; exp_e = 0;
      end else begin
        exp_v = 0; exp_e = 1;
      end
      clear_mon();
      send_frame(data, len, t_rise);
      tick(12);
      got = (v_words.size() > 0) ? v_words[0] : model_omega;
      $display("random frame %0d len=%0d data=%h valids=%0d errs=%0d omega=%h", k, len, data, v_words.size(), e_cnt, omega_out);
      n_checks++;
      if (v_words.size() != exp_v || e_cnt != exp_e) begin
        n_fail++; $display("FAIL rand%0d_pulses got=%0d/%0d exp=%0d/%0d", k, v_words.size(), e_cnt, exp_v, exp_e);
      end
      n_checks++;
      if (omega_out !== model_omega || got !== model_omega) begin
        n_fail++; $display("FAIL rand%0d_omega got=%h exp=%h", k, omega_out, model_omega);
      end
    end
  endtask

  task automatic test_pulse_exclusive();
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_length(W - 1);
    test_bad_length(W + 1);
    test_bad_length(64);
    test_sck_while_idle();
    test_reset_midframe();
    test_back_to_back();
    test_random(12);
    test_pulse_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
